// File: rtl/extbus_pkg.sv
// Shared constants for the external bus responder: FSM state codes and I/O page addresses.
package extbus_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_WAIT   = 2'd1;
  localparam state_t ST_ACCESS = 2'd2;
  localparam state_t ST_RESP   = 2'd3;

  localparam logic [7:0] IO_BASE     = 8'hF0;
  localparam logic [7:0] IO_GPIO_OUT = 8'hF0;
  localparam logic [7:0] IO_GPIO_IN  = 8'hF1;
  localparam logic [7:0] IO_TMR_LO   = 8'hF2;
  localparam logic [7:0] IO_TMR_HI   = 8'hF3;
  localparam logic [7:0] IO_STATUS   = 8'hF4;

  // Writes that must be flagged: every read-only register in the I/O page.
  // TMR_LO is writable only when the timer is built.
  function automatic logic ro_write(input logic [7:0] addr, input logic timer_en);
    case (addr)
      IO_GPIO_IN, IO_TMR_HI, IO_STATUS: return 1'b1;
      IO_TMR_LO:                        return ~timer_en;
      default:                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/extbus_timer.sv
// Prescaled 16-bit free-running timer with high-byte shadow and wrap sticky bit.
// Only instantiated when EXTBUS_TIMER_EN is defined.
module extbus_timer
  import extbus_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clr,
  input  logic       snap,
  input  logic       sticky_clr,
  output logic [7:0] lo,
  output logic [7:0] shadow,
  output logic       wrapped
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_reg;
  logic [15:0]   cnt_reg;
  logic [7:0]    shadow_reg;
  logic          wrap_reg;
  logic          tick;

  assign tick = (pre_reg == PRE_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pre_reg    <= '0;
      cnt_reg    <= 16'h0000;
      shadow_reg <= 8'h00;
      wrap_reg   <= 1'b0;
    end else begin
      if (clr) begin
        pre_reg <= '0;
        cnt_reg <= 16'h0000;
      end else begin
        pre_reg <= tick ? '0 : PW'(pre_reg + 1'b1);
        if (tick) cnt_reg <= cnt_reg + 16'd1;
      end
      if (snap) shadow_reg <= cnt_reg[15:8];
      // A wrap in the same cycle as a STATUS read keeps the bit set.
      if (tick && !clr && cnt_reg == 16'hFFFF) wrap_reg <= 1'b1;
      else if (sticky_clr)                      wrap_reg <= 1'b0;
    end
  end

  assign lo      = cnt_reg[7:0];
  assign shadow  = shadow_reg;
  assign wrapped = wrap_reg;

endmodule

// File: rtl/extern_bus_responder.sv
// External bus far end: data RAM plus GPIO/status/timer I/O page with fixed wait states.
// Optional timer built when EXTBUS_TIMER_EN is defined.
module extern_bus_responder
  import extbus_pkg::*;
#(
  parameter int RAM_DEPTH    = 64,
  parameter int WAIT_CYCLES  = 1,
  parameter int TMR_PRESCALE = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       Req_i,
  input  logic       We_i,
  input  logic [7:0] Addr_i,
  input  logic [7:0] WData_i,
  output logic [7:0] RData_o,
  output logic       Ack_o,
  output logic       Err_o,
  output logic       Busy_o,
  input  logic [7:0] GpioIn_i,
  output logic [7:0] GpioOut_o
);

  localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [8:0] RAM_END = 9'(RAM_DEPTH);
  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
`ifdef EXTBUS_TIMER_EN
  localparam logic TIMER_EN = 1'b1;
`else
  localparam logic TIMER_EN = 1'b0;
`endif

  state_t      state_reg, state_next;
  logic [3:0]  wcnt_reg;
  logic [7:0]  addr_reg, wdata_reg;
  logic        we_reg;
  logic [7:0]  rdata_reg;
  logic        err_reg, sel_ram_reg;
  logic [7:0]  gpio_out_reg;
  logic [7:0]  sync1_reg, sync2_reg;

  logic        is_ram, in_access;
  logic [7:0]  io_rdata;
  logic        acc_err;
  logic [7:0]  tmr_lo, tmr_shadow;
  logic        tmr_wrapped;

  logic [7:0]  ram [0:RAM_DEPTH-1];
  logic [7:0]  ram_q;
  logic [AW-1:0] ram_idx;

  assign is_ram    = ({1'b0, addr_reg} < RAM_END);
  assign in_access = (state_reg == ST_ACCESS);
  assign ram_idx   = addr_reg[AW-1:0];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (Req_i) state_next = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
      ST_WAIT:   if (wcnt_reg == 4'd0) state_next = ST_ACCESS;
      ST_ACCESS: state_next = ST_RESP;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    io_rdata = 8'h00;
    case (addr_reg)
      IO_GPIO_OUT: io_rdata = gpio_out_reg;
      IO_GPIO_IN:  io_rdata = sync2_reg;
      IO_TMR_LO:   io_rdata = tmr_lo;
      IO_TMR_HI:   io_rdata = tmr_shadow;
      IO_STATUS:   io_rdata = {7'b0, tmr_wrapped};
      default:     io_rdata = 8'h00;
    endcase
  end

  // Unmapped: neither RAM nor one of the five I/O registers.
  assign acc_err = (!is_ram && (addr_reg < IO_BASE || addr_reg > IO_STATUS))
                 || (we_reg && ro_write(addr_reg, TIMER_EN));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg    <= ST_IDLE;
      wcnt_reg     <= 4'd0;
      addr_reg     <= 8'h00;
      we_reg       <= 1'b0;
      wdata_reg    <= 8'h00;
      rdata_reg    <= 8'h00;
      err_reg      <= 1'b0;
      sel_ram_reg  <= 1'b0;
      gpio_out_reg <= 8'h00;
      sync1_reg    <= 8'h00;
      sync2_reg    <= 8'h00;
    end else begin
      state_reg <= state_next;
      sync1_reg <= GpioIn_i;
      sync2_reg <= sync1_reg;
      if (state_reg == ST_IDLE && Req_i) begin
        addr_reg  <= Addr_i;
        we_reg    <= We_i;
        wdata_reg <= WData_i;
        wcnt_reg  <= WAIT_LOAD;
      end else if (state_reg == ST_WAIT && wcnt_reg != 4'd0) begin
        wcnt_reg <= wcnt_reg - 4'd1;
      end
      if (in_access) begin
        rdata_reg   <= we_reg ? 8'h00 : io_rdata;
        err_reg     <= acc_err;
        sel_ram_reg <= is_ram && !we_reg;
        if (we_reg && addr_reg == IO_GPIO_OUT) gpio_out_reg <= wdata_reg;
      end
    end
  end

  // Plain synchronous RAM, no reset, so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (in_access && is_ram) begin
      if (we_reg) ram[ram_idx] <= wdata_reg;
      ram_q <= ram[ram_idx];
    end
  end

`ifdef EXTBUS_TIMER_EN
  extbus_timer #(
    .PRESCALE (TMR_PRESCALE)
  ) u_timer (
    .clk        (clk),
    .rstn       (rstn),
    .clr        (in_access && we_reg && addr_reg == IO_TMR_LO),
    .snap       (in_access && !we_reg && addr_reg == IO_TMR_LO),
    .sticky_clr (in_access && !we_reg && addr_reg == IO_STATUS),
    .lo         (tmr_lo),
    .shadow     (tmr_shadow),
    .wrapped    (tmr_wrapped)
  );
`else
  assign tmr_lo      = 8'h00;
  assign tmr_shadow  = 8'h00;
  assign tmr_wrapped = 1'b0;
`endif

  assign Ack_o     = (state_reg == ST_RESP);
  assign Err_o     = (state_reg == ST_RESP) && err_reg;
  assign RData_o   = (state_reg == ST_RESP) ? (sel_ram_reg ? ram_q : rdata_reg) : 8'h00;
  assign Busy_o    = (state_reg == ST_WAIT) || (state_reg == ST_ACCESS)
                   || (state_reg == ST_IDLE && Req_i);
  assign GpioOut_o = gpio_out_reg;

endmodule

// File: tb/tb_extern_bus_responder.sv
// Randomized self-checking bench for extern_bus_responder against an address-map reference model.
// Timer checks are compiled in when EXTBUS_TIMER_EN is defined.
module tb_extern_bus_responder;

  localparam int TB_DEPTH = 64;
  localparam int TB_WAIT  = 1;
  localparam int TB_PRE   = 1;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       Req_i = 1'b0;
  logic       We_i = 1'b0;
  logic [7:0] Addr_i = 8'h00;
  logic [7:0] WData_i = 8'h00;
  logic [7:0] GpioIn_i;
  logic [7:0] RData_o;
  logic       Ack_o, Err_o, Busy_o;
  logic [7:0] GpioOut_o;

  extern_bus_responder #(
    .RAM_DEPTH    (TB_DEPTH),
    .WAIT_CYCLES  (TB_WAIT),
    .TMR_PRESCALE (TB_PRE)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .Req_i     (Req_i),
    .We_i      (We_i),
    .Addr_i    (Addr_i),
    .WData_i   (WData_i),
    .RData_o   (RData_o),
    .Ack_o     (Ack_o),
    .Err_o     (Err_o),
    .Busy_o    (Busy_o),
    .GpioIn_i  (GpioIn_i),
    .GpioOut_o (GpioOut_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [7:0] m_ram [0:255];
  bit         m_valid [0:255];
  logic [7:0] m_gpio = 8'h00;
  logic [7:0] g_in = 8'h00;
  assign GpioIn_i = g_in;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives one bus access from a negedge; returns data/err seen in the Ack cycle,
  // the latency in cycles and the clock edge at which the access took effect.
  task automatic bus_txn(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                         input bit drop, output logic [7:0] rd, output logic err,
                         output int lat, output int commit);
    bit got = 0;
    Req_i = 1'b1; We_i = we; Addr_i = addr; WData_i = wdata;
    #1 check_val("busy_on_req", 16'(Busy_o), 16'h1);
    lat = 0; rd = 8'h00; err = 1'b0; commit = 0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (drop) Req_i = 1'b0;
      if (Ack_o) begin
        got = 1;
        rd = RData_o; err = Err_o; commit = cyc;
        check_val("busy_in_resp", 16'(Busy_o), 16'h0);
        Req_i = 1'b0;
      end else begin
        check_val("busy_stall", 16'(Busy_o), 16'h1);
        We_i = 1'($urandom); Addr_i = 8'($urandom); WData_i = 8'($urandom);
      end
    end
    if (!got) check_val("ack_timeout", 16'h0, 16'h1);
    @(negedge clk);
    check_val("ack_single", 16'(Ack_o), 16'h0);
    check_val("rdata_idle", 16'(RData_o), 16'h0);
    check_val("err_idle", 16'(Err_o), 16'h0);
    check_val("busy_idle", 16'(Busy_o), 16'h0);
    $display("[TB] txn we=%0d addr=%02h wdata=%02h drop=%0d -> rdata=%02h err=%0d lat=%0d",
             we, addr, wdata, drop, rd, err, lat);
  endtask

  // Expected outcome of one access derived from the address map.
  task automatic model_txn(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                           output logic [7:0] exp_rd, output logic exp_err, output bit known);
    exp_rd = 8'h00; exp_err = 1'b0; known = 1;
    if (int'(addr) < TB_DEPTH) begin
      if (we) begin m_ram[addr] = wdata; m_valid[addr] = 1; end
      else begin exp_rd = m_ram[addr]; known = m_valid[addr]; end
    end else begin
      case (addr)
        8'hF0: if (we) m_gpio = wdata; else exp_rd = m_gpio;
        8'hF1: if (we) exp_err = 1'b1; else exp_rd = g_in;
`ifdef EXTBUS_TIMER_EN
        8'hF2: begin exp_err = 1'b0; known = 0; end
        8'hF3, 8'hF4: begin exp_err = we; known = 0; end
`else
        8'hF2, 8'hF3, 8'hF4: exp_err = we;
`endif
        default: exp_err = 1'b1;
      endcase
    end
  endtask

  task automatic run_check(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                           input bit drop);
    logic [7:0] rd, exp_rd;
    logic err, exp_err;
    bit known;
    int lat, commit;
    bus_txn(we, addr, wdata, drop, rd, err, lat, commit);
    model_txn(we, addr, wdata, exp_rd, exp_err, known);
    check_val("latency", 16'(lat), 16'(TB_WAIT + 2));
    check_val("err", 16'(err), 16'(exp_err));
    if (!we && known) check_val("rdata", 16'(rd), 16'(exp_rd));
    check_val("gpio_out", 16'(GpioOut_o), 16'(m_gpio));
  endtask

  task automatic set_gpio_in(input logic [7:0] v);
    g_in = v;
    repeat (3) @(negedge clk);
  endtask

`ifdef EXTBUS_TIMER_EN
  int clr_edge = 0;
  function automatic logic [15:0] tval(input int commit);
    return 16'(((commit - 1 - clr_edge) / TB_PRE) & 32'hFFFF);
  endfunction

  task automatic timer_tests();
    logic [7:0] rd;
    logic err;
    int lat, commit;
    logic [15:0] v;
    bus_txn(1'b1, 8'hF2, 8'h00, 0, rd, err, lat, commit);
    check_val("tmr_clr_err", 16'(err), 16'h0);
    clr_edge = commit;
    while ((cyc + TB_WAIT + 2 - 1 - clr_edge) / TB_PRE < 32'h1FF) @(negedge clk);
    bus_txn(1'b0, 8'hF2, 8'h00, 0, rd, err, lat, commit);
    v = tval(commit);
    check_val("tmr_lo_1ff", 16'(rd), 16'(v[7:0]));
    check_val("tmr_preload", v, 16'h01FF);
    repeat (300) @(negedge clk);
    bus_txn(1'b0, 8'hF3, 8'h00, 0, rd, err, lat, commit);
    check_val("tmr_shadow", 16'(rd), 16'(v[15:8]));
    bus_txn(1'b0, 8'hF4, 8'h00, 0, rd, err, lat, commit);
    check_val("status_prewrap", 16'(rd), 16'h0);
    while ((cyc - clr_edge) / TB_PRE < 65536 + 8) @(negedge clk);
    bus_txn(1'b0, 8'hF4, 8'h00, 0, rd, err, lat, commit);
    check_val("status_wrap", 16'(rd), 16'h1);
    bus_txn(1'b0, 8'hF4, 8'h00, 0, rd, err, lat, commit);
    check_val("status_cleared", 16'(rd), 16'h0);
  endtask
`endif

  initial begin
    logic [7:0] a;
    int r;
    for (int i = 0; i < 256; i++) m_valid[i] = 0;
    repeat (3) @(negedge clk);
    check_val("rst_ack", 16'(Ack_o), 16'h0);
    check_val("rst_err", 16'(Err_o), 16'h0);
    check_val("rst_rdata", 16'(RData_o), 16'h0);
    check_val("rst_gpio", 16'(GpioOut_o), 16'h0);
    check_val("rst_busy", 16'(Busy_o), 16'h0);
    rstn = 1'b1;
    @(negedge clk);

    run_check(1'b1, 8'h10, 8'h5A, 0);
    run_check(1'b0, 8'h10, 8'h00, 0);
    run_check(1'b1, 8'hF0, 8'hA5, 0);
    set_gpio_in(8'h3C);
    run_check(1'b0, 8'hF1, 8'h00, 0);
    run_check(1'b0, 8'h80, 8'h00, 0);
    run_check(1'b1, 8'hF1, 8'h99, 0);
    run_check(1'b1, 8'h05, 8'h77, 1);
    run_check(1'b0, 8'h05, 8'h00, 0);
    run_check(1'b1, 8'h3F, 8'hC3, 0);
    run_check(1'b0, 8'h3F, 8'h00, 0);
    run_check(1'b1, 8'h40, 8'h12, 0);
`ifdef EXTBUS_TIMER_EN
    timer_tests();
`else
    run_check(1'b0, 8'hF2, 8'h00, 0);
    run_check(1'b0, 8'hF3, 8'h00, 0);
    run_check(1'b0, 8'hF4, 8'h00, 0);
    run_check(1'b1, 8'hF2, 8'h44, 0);
`endif

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) == 0) set_gpio_in(8'($urandom));
      r = int'($urandom_range(0, 9));
      case (r)
        5: a = 8'hF0;
        6: a = 8'hF1;
`ifdef EXTBUS_TIMER_EN
        7: a = 8'hF0;
`else
        7: a = 8'($urandom_range(242, 244));
`endif
        8: a = $urandom_range(0, 1) ? 8'($urandom_range(TB_DEPTH, 239)) : 8'($urandom_range(245, 255));
        9: a = $urandom_range(0, 1) ? 8'(TB_DEPTH - 1) : 8'(TB_DEPTH);
        default: a = 8'($urandom_range(0, TB_DEPTH - 1));
      endcase
      run_check(1'($urandom), a, 8'($urandom), $urandom_range(0, 3) == 0);
    end

    // Reset in the middle of a wait state.
    run_check(1'b1, 8'hF0, 8'h5C, 0);
    Req_i = 1'b1; We_i = 1'b1; Addr_i = 8'hF0; WData_i = 8'h11;
    @(negedge clk);
    rstn = 1'b0; Req_i = 1'b0;
    m_gpio = 8'h00;
    #1;
    check_val("midrst_ack", 16'(Ack_o), 16'h0);
    check_val("midrst_busy", 16'(Busy_o), 16'h0);
    check_val("midrst_gpio", 16'(GpioOut_o), 16'h0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_val("postrst_ack", 16'(Ack_o), 16'h0);
      check_val("postrst_gpio", 16'(GpioOut_o), 16'h0);
    end
    run_check(1'b0, 8'h10, 8'h00, 0);
    run_check(1'b0, 8'hF0, 8'h00, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
